// File: rtl/ssd1331_spi_receiver_pkg.sv
// ============================================================================
// Module   : ssd1331_spi_receiver_pkg
// Brief    : Shared opcodes, reset constants and decoder states for the
//            SSD1331 SPI receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd1331_spi_receiver_pkg;

  localparam logic [7:0] c_OP_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] c_OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] c_OP_REMAP       = 8'hA0;
  localparam logic [7:0] c_OP_COL_ADDR    = 8'h15;
  localparam logic [7:0] c_OP_ROW_ADDR    = 8'h75;

  localparam logic [7:0] c_REMAP_DEFAULT  = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/ssd1331_spi_receiver_spi_byte_deframer.sv
// ============================================================================
// Module   : ssd1331_spi_receiver_spi_byte_deframer
// Brief    : Oversampled SPI slave front end: synchronizers, SCK edge detect,
//            byte assembly with CS abort, optional SCK period check
//            (SSD1331_RX_TIMING_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd1331_spi_receiver_spi_byte_deframer #(
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_SCK_PERIOD = 15
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_cs,
  input  logic       i_mosi,
  input  logic       i_sck,
  input  logic       i_dc,
  input  logic       i_res,
  output logic       o_res_n,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_byte_dc,
  output logic       o_timing_err
);

  // Bit order {res, dc, sck, mosi, cs}; idle-high lines reset high.
  localparam logic [4:0] c_SYNC_RST = 5'b10001;

  logic [4:0] r_sync [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge i_CLK) begin
          if (i_RST) r_sync[gi] <= c_SYNC_RST;
          else       r_sync[gi] <= {i_res, i_dc, i_sck, i_mosi, i_cs};
        end
      end else begin : g_next
        always_ff @(posedge i_CLK) begin
          if (i_RST) r_sync[gi] <= c_SYNC_RST;
          else       r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  logic [4:0] w_s;
  logic       w_cs, w_mosi, w_sck, w_dc, w_res_n, w_rise, w_srst;

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_cs    = w_s[0];
  assign w_mosi  = w_s[1];
  assign w_sck   = w_s[2];
  assign w_dc    = w_s[3];
  assign w_res_n = w_s[4];
  assign w_srst  = i_RST | ~w_res_n;

  logic       r_sck_prev;
  logic [2:0] r_cnt;
  logic [6:0] r_shift;
  logic       r_valid, r_dc;
  logic [7:0] r_byte;

  assign w_rise = w_sck & ~r_sck_prev & ~w_cs;

  always_ff @(posedge i_CLK) begin
    if (i_RST) r_sck_prev <= 1'b0;
    else       r_sck_prev <= w_sck;
  end

  always_ff @(posedge i_CLK) begin
    if (w_srst) begin
      r_cnt   <= 3'd0;
      r_shift <= 7'd0;
      r_byte  <= 8'd0;
      r_dc    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_cs) begin
        r_cnt <= 3'd0;
      end else if (w_rise) begin
        r_shift <= {r_shift[5:0], w_mosi};
        r_cnt   <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_byte  <= {r_shift, w_mosi};
          r_dc    <= w_dc;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign o_res_n      = w_res_n;
  assign o_byte_valid = r_valid;
  assign o_byte       = r_byte;
  assign o_byte_dc    = r_dc;

`ifdef SSD1331_RX_TIMING_CHECK_EN
  localparam int c_PER_W = $clog2(MIN_SCK_PERIOD) + 1;

  // r_per holds ticks since the previous rise minus one; saturates.
  logic [c_PER_W-1:0] r_per;
  logic               r_seen, r_terr;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_per  <= '0;
      r_seen <= 1'b0;
      r_terr <= 1'b0;
    end else begin
      if (w_cs) r_seen <= 1'b0;
      if (w_rise) begin
        if (r_seen && (r_per < c_PER_W'(MIN_SCK_PERIOD - 1))) r_terr <= 1'b1;
        r_seen <= 1'b1;
        r_per  <= '0;
      end else if (r_per != '1) begin
        r_per <= r_per + 1'b1;
      end
    end
  end

  assign o_timing_err = r_terr;
`else
  localparam int c_unused_min_sck = MIN_SCK_PERIOD;
  assign o_timing_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/ssd1331_spi_receiver.sv
// ============================================================================
// Module   : ssd1331_spi_receiver
// Brief    : SSD1331 SPI slave model: command decode, window addressing and
//            pixel write generation. SCK period check under
//            SSD1331_RX_TIMING_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd1331_spi_receiver
  import ssd1331_spi_receiver_pkg::*;
#(
  parameter int NUM_COL        = 96,
  parameter int NUM_ROW        = 64,
  parameter int N_COLOR_BITS   = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_SCK_PERIOD = 15
) (
  input  logic                    i_CLK,
  input  logic                    i_RST,
  input  logic                    i_CS,
  input  logic                    i_MOSI,
  input  logic                    i_SCK,
  input  logic                    i_DC,
  input  logic                    i_RES,
  output logic                    o_BYTE_VALID,
  output logic [7:0]              o_BYTE,
  output logic                    o_BYTE_DC,
  output logic                    o_PIX_WE,
  output logic [6:0]              o_PIX_COL,
  output logic [5:0]              o_PIX_ROW,
  output logic [N_COLOR_BITS-1:0] o_PIX_DATA,
  output logic                    o_DISPLAY_ON,
  output logic [7:0]              o_REMAP,
  output logic                    o_CMD_ERR,
  output logic                    o_TIMING_ERR
);

  logic       w_res_n, w_bv, w_bdc, w_rst;
  logic [7:0] w_byte;

  ssd1331_spi_receiver_spi_byte_deframer #(
    .SYNC_STAGES   (SYNC_STAGES),
    .MIN_SCK_PERIOD(MIN_SCK_PERIOD)
  ) u_deframer (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_cs        (i_CS),
    .i_mosi      (i_MOSI),
    .i_sck       (i_SCK),
    .i_dc        (i_DC),
    .i_res       (i_RES),
    .o_res_n     (w_res_n),
    .o_byte_valid(w_bv),
    .o_byte      (w_byte),
    .o_byte_dc   (w_bdc),
    .o_timing_err(o_TIMING_ERR)
  );

  assign w_rst = i_RST | ~w_res_n;

  rx_state_t  r_state, w_state_nx;
  logic [7:0] r_opcode, r_remap;
  logic [6:0] r_arg1, r_col_start, r_col_end, r_col_ptr;
  logic [5:0] r_row_start, r_row_end, r_row_ptr;
  logic       r_disp;

  // Out-of-range window arguments clamp to the last column/row.
  logic       w_col_oor, w_row_oor, w_is_col, w_oor;
  logic [6:0] w_col_arg;
  logic [5:0] w_row_arg;

  assign w_col_oor = (w_byte >= 8'(NUM_COL));
  assign w_row_oor = (w_byte >= 8'(NUM_ROW));
  assign w_col_arg = w_col_oor ? 7'(NUM_COL - 1) : w_byte[6:0];
  assign w_row_arg = w_row_oor ? 6'(NUM_ROW - 1) : w_byte[5:0];
  assign w_is_col  = (r_opcode == c_OP_COL_ADDR);
  assign w_oor     = w_is_col ? w_col_oor : w_row_oor;

  logic w_pix_we, w_cmd_err, w_ld_op, w_disp_on, w_disp_off;
  logic w_ld_remap, w_ld_arg1, w_commit;

  always_comb begin
    w_state_nx = r_state;
    w_pix_we   = 1'b0;
    w_cmd_err  = 1'b0;
    w_ld_op    = 1'b0;
    w_disp_on  = 1'b0;
    w_disp_off = 1'b0;
    w_ld_remap = 1'b0;
    w_ld_arg1  = 1'b0;
    w_commit   = 1'b0;
    if (w_bv) begin
      if (w_bdc) begin
        // Data in mid-command aborts the command but is still drawn.
        w_pix_we = 1'b1;
        if (r_state != ST_IDLE) begin
          w_cmd_err  = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            case (w_byte)
              c_OP_DISPLAY_ON:  w_disp_on  = 1'b1;
              c_OP_DISPLAY_OFF: w_disp_off = 1'b1;
              c_OP_REMAP, c_OP_COL_ADDR, c_OP_ROW_ADDR: begin
                w_ld_op    = 1'b1;
                w_state_nx = ST_ARG1;
              end
              default: w_cmd_err = 1'b1;
            endcase
          end
          ST_ARG1: begin
            if (r_opcode == c_OP_REMAP) begin
              w_ld_remap = 1'b1;
              w_state_nx = ST_IDLE;
            end else begin
              w_ld_arg1  = 1'b1;
              w_cmd_err  = w_oor;
              w_state_nx = ST_ARG2;
            end
          end
          ST_ARG2: begin
            w_commit   = 1'b1;
            w_cmd_err  = w_oor;
            w_state_nx = ST_IDLE;
          end
          default: w_state_nx = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge i_CLK) begin
    if (w_rst) begin
      r_opcode    <= 8'd0;
      r_remap     <= c_REMAP_DEFAULT;
      r_disp      <= 1'b0;
      r_arg1      <= 7'd0;
      r_col_start <= 7'd0;
      r_col_end   <= 7'(NUM_COL - 1);
      r_col_ptr   <= 7'd0;
      r_row_start <= 6'd0;
      r_row_end   <= 6'(NUM_ROW - 1);
      r_row_ptr   <= 6'd0;
    end else begin
      if (w_ld_op)    r_opcode <= w_byte;
      if (w_disp_on)  r_disp   <= 1'b1;
      if (w_disp_off) r_disp   <= 1'b0;
      if (w_ld_remap) r_remap  <= w_byte;
      if (w_ld_arg1)  r_arg1   <= w_is_col ? w_col_arg : {1'b0, w_row_arg};
      if (w_commit) begin
        if (w_is_col) begin
          r_col_start <= r_arg1;
          r_col_end   <= w_col_arg;
          r_col_ptr   <= r_arg1;
        end else begin
          r_row_start <= r_arg1[5:0];
          r_row_end   <= w_row_arg;
          r_row_ptr   <= r_arg1[5:0];
        end
      end
      // Wrap on the window end or the array edge, whichever comes first.
      if (w_pix_we) begin
        if ((r_col_ptr == r_col_end) || (r_col_ptr == 7'(NUM_COL - 1))) begin
          r_col_ptr <= r_col_start;
          if ((r_row_ptr == r_row_end) || (r_row_ptr == 6'(NUM_ROW - 1)))
            r_row_ptr <= r_row_start;
          else
            r_row_ptr <= r_row_ptr + 6'd1;
        end else begin
          r_col_ptr <= r_col_ptr + 7'd1;
        end
      end
    end
  end

  assign o_BYTE_VALID = w_bv;
  assign o_BYTE       = w_byte;
  assign o_BYTE_DC    = w_bdc;
  assign o_PIX_WE     = w_pix_we;
  assign o_PIX_COL    = r_col_ptr;
  assign o_PIX_ROW    = r_row_ptr;
  assign o_PIX_DATA   = N_COLOR_BITS'(w_byte);
  assign o_DISPLAY_ON = r_disp;
  assign o_REMAP      = r_remap;
  assign o_CMD_ERR    = w_cmd_err;

endmodule

`default_nettype wire

// File: tb/tb_ssd1331_spi_receiver.sv
// ============================================================================
// Module   : tb_ssd1331_spi_receiver
// Brief    : Self-checking bench for ssd1331_spi_receiver; directed vector
//            table, corner sequences and a random run against a panel model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssd1331_spi_receiver;

  localparam int NUM_COL = 96;
  localparam int NUM_ROW = 64;

  logic       clk = 1'b0;
  logic       rst, cs, mosi, sck, dc, res;
  logic       o_BYTE_VALID, o_BYTE_DC, o_PIX_WE, o_DISPLAY_ON, o_CMD_ERR, o_TIMING_ERR;
  logic [7:0] o_BYTE, o_PIX_DATA, o_REMAP;
  logic [6:0] o_PIX_COL;
  logic [5:0] o_PIX_ROW;

  ssd1331_spi_receiver dut (
    .i_CLK(clk), .i_RST(rst), .i_CS(cs), .i_MOSI(mosi), .i_SCK(sck),
    .i_DC(dc), .i_RES(res),
    .o_BYTE_VALID(o_BYTE_VALID), .o_BYTE(o_BYTE), .o_BYTE_DC(o_BYTE_DC),
    .o_PIX_WE(o_PIX_WE), .o_PIX_COL(o_PIX_COL), .o_PIX_ROW(o_PIX_ROW),
    .o_PIX_DATA(o_PIX_DATA), .o_DISPLAY_ON(o_DISPLAY_ON), .o_REMAP(o_REMAP),
    .o_CMD_ERR(o_CMD_ERR), .o_TIMING_ERR(o_TIMING_ERR)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Event capture, sampled on the falling edge.
  int         n_valid = 0, n_err = 0, n_we = 0;
  logic [7:0] cap_byte, cap_data;
  logic       cap_dc;
  logic [6:0] cap_col;
  logic [5:0] cap_row;

  always @(negedge clk) begin
    if (o_BYTE_VALID) begin
      n_valid++;
      cap_byte = o_BYTE;
      cap_dc   = o_BYTE_DC;
    end
    if (o_CMD_ERR) n_err++;
    if (o_PIX_WE) begin
      n_we++;
      cap_col  = o_PIX_COL;
      cap_row  = o_PIX_ROW;
      cap_data = o_PIX_DATA;
      if (!o_BYTE_VALID) begin
        bad++;
        $display("FAIL we_align: got WE without BYTE_VALID");
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d, input int half);
    cs = 1'b0;
    dc = d;
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      sck  = 1'b0;
      tick(half);
      sck  = 1'b1;
      tick(half);
    end
    sck = 1'b0;
    tick(half);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    tick(4);
  endtask

  // Panel model: command bytes collected until complete, then applied.
  int         m_disp, m_remap, m_cs, m_ce, m_rs, m_re, m_cp, m_rp;
  logic [7:0] pend[$];

  task automatic model_reset();
    m_disp = 0; m_remap = 'h40;
    m_cs = 0; m_ce = NUM_COL - 1; m_rs = 0; m_re = NUM_ROW - 1;
    m_cp = 0; m_rp = 0;
    pend.delete();
  endtask

  task automatic model_step(input logic [7:0] b, input logic d,
                            output int e_err, output int e_we, output int e_col, output int e_row);
    int lim, s, e;
    e_err = 0; e_we = 0; e_col = m_cp; e_row = m_rp;
    if (d) begin
      if (pend.size() != 0) begin e_err = 1; pend.delete(); end
      e_we = 1;
      if (m_cp == m_ce || m_cp == NUM_COL - 1) begin
        m_cp = m_cs;
        if (m_rp == m_re || m_rp == NUM_ROW - 1) m_rp = m_rs;
        else m_rp = m_rp + 1;
      end else m_cp = m_cp + 1;
    end else if (pend.size() == 0) begin
      if (b == 8'hAF) m_disp = 1;
      else if (b == 8'hAE) m_disp = 0;
      else if (b == 8'hA0 || b == 8'h15 || b == 8'h75) pend.push_back(b);
      else e_err = 1;
    end else if (pend[0] == 8'hA0) begin
      m_remap = b;
      pend.delete();
    end else begin
      lim = (pend[0] == 8'h15) ? NUM_COL : NUM_ROW;
      if (int'(b) >= lim) e_err = 1;
      pend.push_back(b);
      if (pend.size() == 3) begin
        s = (int'(pend[1]) >= lim) ? lim - 1 : int'(pend[1]);
        e = (int'(pend[2]) >= lim) ? lim - 1 : int'(pend[2]);
        if (pend[0] == 8'h15) begin m_cs = s; m_ce = e; m_cp = s; end
        else begin m_rs = s; m_re = e; m_rp = s; end
        pend.delete();
      end
    end
  endtask

  typedef struct packed {
    logic [7:0] b;
    logic       dc;
    logic       err;
    logic       we;
    logic [6:0] col;
    logic [5:0] row;
    logic       disp;
    logic [7:0] remap;
  } vec_t;

  vec_t vecs [25];

  initial begin
    int v0, e0, w0, e_err, e_we, e_col, e_row;
    logic [7:0] rb;
    logic       rd;

    rst = 1'b1; cs = 1'b1; mosi = 1'b0; sck = 1'b0; dc = 1'b0; res = 1'b1;
    vecs[0]  = '{8'hAF, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h40};
    vecs[1]  = '{8'hA0, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h40};
    vecs[2]  = '{8'h52, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[3]  = '{8'h15, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[4]  = '{8'h0A, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[5]  = '{8'h0C, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[6]  = '{8'h75, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[7]  = '{8'h05, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[8]  = '{8'h06, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[9]  = '{8'h01, 1'b1, 1'b0, 1'b1, 7'd10, 6'd5, 1'b1, 8'h52};
    vecs[10] = '{8'h02, 1'b1, 1'b0, 1'b1, 7'd11, 6'd5, 1'b1, 8'h52};
    vecs[11] = '{8'h03, 1'b1, 1'b0, 1'b1, 7'd12, 6'd5, 1'b1, 8'h52};
    vecs[12] = '{8'h04, 1'b1, 1'b0, 1'b1, 7'd10, 6'd6, 1'b1, 8'h52};
    vecs[13] = '{8'h05, 1'b1, 1'b0, 1'b1, 7'd11, 6'd6, 1'b1, 8'h52};
    vecs[14] = '{8'h06, 1'b1, 1'b0, 1'b1, 7'd12, 6'd6, 1'b1, 8'h52};
    vecs[15] = '{8'h07, 1'b1, 1'b0, 1'b1, 7'd10, 6'd5, 1'b1, 8'h52};
    vecs[16] = '{8'hBB, 1'b0, 1'b1, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[17] = '{8'h15, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[18] = '{8'h70, 1'b0, 1'b1, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[19] = '{8'h05, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[20] = '{8'h15, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[21] = '{8'h03, 1'b0, 1'b0, 1'b0, 7'd0,  6'd0, 1'b1, 8'h52};
    vecs[22] = '{8'h99, 1'b1, 1'b1, 1'b1, 7'd95, 6'd5, 1'b1, 8'h52};
    vecs[23] = '{8'hAA, 1'b1, 1'b0, 1'b1, 7'd95, 6'd6, 1'b1, 8'h52};
    vecs[24] = '{8'hAB, 1'b1, 1'b0, 1'b1, 7'd95, 6'd5, 1'b1, 8'h52};

    do_reset();
    chk("rst_valid", o_BYTE_VALID, 0);
    chk("rst_byte", o_BYTE, 0);
    chk("rst_byte_dc", o_BYTE_DC, 0);
    chk("rst_we", o_PIX_WE, 0);
    chk("rst_col", o_PIX_COL, 0);
    chk("rst_row", o_PIX_ROW, 0);
    chk("rst_data", o_PIX_DATA, 0);
    chk("rst_disp", o_DISPLAY_ON, 0);
    chk("rst_remap", o_REMAP, 'h40);
    chk("rst_err", o_CMD_ERR, 0);
    chk("rst_terr", o_TIMING_ERR, 0);

    for (int i = 0; i < 25; i++) begin
      v0 = n_valid; e0 = n_err; w0 = n_we;
      send_byte(vecs[i].b, vecs[i].dc, 10);
      chk($sformatf("v%0d_valid", i), n_valid - v0, 1);
      chk($sformatf("v%0d_byte", i), cap_byte, vecs[i].b);
      chk($sformatf("v%0d_bdc", i), cap_dc, vecs[i].dc);
      chk($sformatf("v%0d_err", i), n_err - e0, vecs[i].err);
      chk($sformatf("v%0d_we", i), n_we - w0, vecs[i].we);
      if (vecs[i].we) begin
        chk($sformatf("v%0d_col", i), cap_col, vecs[i].col);
        chk($sformatf("v%0d_row", i), cap_row, vecs[i].row);
        chk($sformatf("v%0d_data", i), cap_data, vecs[i].b);
      end
      chk($sformatf("v%0d_disp", i), o_DISPLAY_ON, vecs[i].disp);
      chk($sformatf("v%0d_remap", i), o_REMAP, vecs[i].remap);
    end
    cs = 1'b1;
    tick(6);

    // Partial byte dropped by CS rising.
    v0 = n_valid;
    cs = 1'b0; dc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; sck = 1'b0; tick(10); sck = 1'b1; tick(10);
    end
    sck = 1'b0; tick(5);
    cs = 1'b1; tick(10);
    chk("abort_none", n_valid - v0, 0);
    send_byte(8'hAE, 1'b0, 10);
    cs = 1'b1; tick(6);
    chk("abort_cnt", n_valid - v0, 1);
    chk("abort_byte", cap_byte, 8'hAE);
    chk("abort_disp", o_DISPLAY_ON, 0);

    // Panel reset mid-byte.
    send_byte(8'hAF, 1'b0, 10);
    chk("pre_res_disp", o_DISPLAY_ON, 1);
    v0 = n_valid;
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b0; sck = 1'b0; tick(10); sck = 1'b1; tick(10);
    end
    sck = 1'b0;
    res = 1'b0;
    tick(10);
    chk("res_disp", o_DISPLAY_ON, 0);
    chk("res_remap", o_REMAP, 'h40);
    chk("res_byte", o_BYTE, 0);
    res = 1'b1;
    tick(5);
    cs = 1'b1; tick(6);
    w0 = n_we;
    send_byte(8'h3C, 1'b1, 10);
    chk("res_cnt", n_valid - v0, 1);
    chk("res_we", n_we - w0, 1);
    chk("res_col", cap_col, 0);
    chk("res_row", cap_row, 0);
    chk("res_data", cap_data, 8'h3C);
    send_byte(8'h3D, 1'b1, 10);
    chk("res_col2", cap_col, 1);
    chk("res_row2", cap_row, 0);
    cs = 1'b1; tick(6);

    // Random traffic against the panel model.
    do_reset();
    model_reset();
    for (int i = 0; i < 150; i++) begin
      rd = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 7))
        0: rb = 8'hAF;
        1: rb = 8'hAE;
        2: rb = 8'hA0;
        3: rb = 8'h15;
        4: rb = 8'h75;
        5, 6: rb = 8'($urandom_range(0, 110));
        default: rb = 8'($urandom_range(0, 255));
      endcase
      model_step(rb, rd, e_err, e_we, e_col, e_row);
      v0 = n_valid; e0 = n_err; w0 = n_we;
      send_byte(rb, rd, 10);
      chk("rnd_valid", n_valid - v0, 1);
      chk("rnd_byte", cap_byte, rb);
      chk("rnd_err", n_err - e0, e_err);
      chk("rnd_we", n_we - w0, e_we);
      if (e_we != 0) begin
        chk("rnd_col", cap_col, e_col);
        chk("rnd_row", cap_row, e_row);
        chk("rnd_data", cap_data, rb);
      end
      chk("rnd_disp", o_DISPLAY_ON, m_disp);
      chk("rnd_remap", o_REMAP, m_remap);
      if ($urandom_range(0, 9) == 0) begin
        cs = 1'b1; tick(4);
      end
    end
    cs = 1'b1; tick(6);
    chk("terr_slow", o_TIMING_ERR, 0);

`ifdef SSD1331_RX_TIMING_CHECK_EN
    send_byte(8'h5A, 1'b1, 5);
    cs = 1'b1; tick(6);
    chk("terr_fast", o_TIMING_ERR, 1);
    send_byte(8'h5B, 1'b1, 10);
    res = 1'b0; tick(10); res = 1'b1; tick(5);
    chk("terr_sticky", o_TIMING_ERR, 1);
    do_reset();
    chk("terr_clear", o_TIMING_ERR, 0);
`else
    send_byte(8'h5A, 1'b1, 5);
    cs = 1'b1; tick(6);
    chk("terr_tied", o_TIMING_ERR, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssd1331_spi_receiver.md
Name: ssd1331_spi_receiver

Overview:
Synthesizable model of the SSD1331 panel's SPI slave. It watches the CS/MOSI/SCK/DC/RES lines driven by the OLED controller, assembles bytes, decodes the command subset the controller uses, and emits pixel writes with the panel's window addressing and auto-increment. It is used in loopback benches and on-FPGA self-checks; it is oversampled on the system clock and never drives the SPI bus.

Parameters:
NUM_COL, 96, columns in the panel array
NUM_ROW, 64, rows in the panel array
N_COLOR_BITS, 8, pixel data width (256-colour mode)
SYNC_STAGES, 2, synchronizer flops on each SPI input
MIN_SCK_PERIOD, 15, minimum legal SCK period in i_CLK ticks (150 ns at 100 MHz)

Ports:
i_CLK  in  1  system clock (100 MHz)
i_RST  in  1  synchronous active-high reset
i_CS  in  1  chip select, active low
i_MOSI  in  1  serial data, MSB first
i_SCK  in  1  serial clock; MOSI sampled on the rising edge
i_DC  in  1  0 = command/argument, 1 = pixel data
i_RES  in  1  panel reset, active low
o_BYTE_VALID  out  1  one-cycle pulse per completed byte
o_BYTE  out  8  last completed byte
o_BYTE_DC  out  1  DC value captured with o_BYTE
o_PIX_WE  out  1  one-cycle pixel write strobe
o_PIX_COL  out  7  column of the pixel write
o_PIX_ROW  out  6  row of the pixel write
o_PIX_DATA  out  N_COLOR_BITS  pixel colour
o_DISPLAY_ON  out  1  state set by 0xAF and cleared by 0xAE
o_REMAP  out  8  last 0xA0 argument
o_CMD_ERR  out  1  one-cycle pulse on a protocol error
o_TIMING_ERR  out  1  sticky SCK timing violation (see Optional Feature)

Behaviour:
- Synchronous active-high reset on i_CLK is defined as follows.
  - All strobes are 0 and o_BYTE/o_BYTE_DC are 0.
  - o_DISPLAY_ON=0, o_REMAP=8'h40.
  - Column window is 0..NUM_COL-1 and row window is 0..NUM_ROW-1.
  - Pointers are at (0,0) and o_PIX_* are 0.
  - The bit counter is 0, the FSM is in IDLE and o_TIMING_ERR=0.
- Input path: each SPI input passes through SYNC_STAGES flops. A synced SCK 0->1 edge samples the synced MOSI.
- Deframing:
  - Synced CS high clears the bit counter and drops any partial byte; nothing is emitted for it.
  - Edges are ignored while CS is high.
  - The 8th edge completes the byte, latching the shift value and DC.
  - o_BYTE_VALID pulses one cycle later, i.e. SYNC_STAGES+1 i_CLK cycles after the raw SCK rise.
- Synced i_RES low has the same effect as i_RST on everything except o_TIMING_ERR. It holds for as long as RES is low.
- Decoder FSM: IDLE, ARG1, ARG2. A latched opcode register remembers the pending command.
  - DC=0 in IDLE:
    - 0xAF sets display on; 0xAE clears it; both stay in IDLE.
    - 0xA0 goes to ARG1.
    - 0x15 and 0x75 go to ARG1 and then ARG2.
    - Any other opcode pulses o_CMD_ERR and stays in IDLE.
  - Argument bytes (DC=0 in ARG1/ARG2):
    - 0xA0 argument is written to o_REMAP.
    - 0x15 arguments are col_start then col_end.
    - 0x75 arguments are row_start then row_end.
    - An out-of-range argument (>= NUM_COL or >= NUM_ROW) is clamped to the maximum and pulses o_CMD_ERR.
    - Completing a 0x15 command sets col_ptr to col_start; completing 0x75 sets row_ptr to row_start. The FSM then returns to IDLE.
  - DC=1 during ARG1/ARG2: o_CMD_ERR pulses, the command is aborted without any register update, and the FSM goes to IDLE. The byte is still treated as pixel data.
  - DC=1 in IDLE (or after an abort):
    - o_PIX_WE pulses in the same cycle as o_BYTE_VALID, with COL=col_ptr, ROW=row_ptr, DATA=byte.
    - After the write, col_ptr advances. At col_end it wraps to col_start and row_ptr advances. At row_end row_ptr wraps to row_start.
    - Pixel writes occur regardless of o_DISPLAY_ON.
  - A window with start > end is legal. The pointer wraps when it equals end, or when it reaches the array maximum.

Optional Feature:
SSD1331_RX_TIMING_CHECK_EN
- Defined:
  - A counter measures i_CLK ticks between synced SCK rising edges while CS is low.
  - A period shorter than MIN_SCK_PERIOD sets o_TIMING_ERR, which stays set until i_RST.
  - The first edge after CS falls is not measured.
- Undefined: o_TIMING_ERR is tied to 0 and no counter is built.

Decomposition:
- Shared ssd1331 defines: opcode constants (0xAF, 0xAE, 0xA0, 0x15, 0x75), the default remap 8'h40, and FSM state encodings.
- One sub-module, spi_byte_deframer, covers synchronizers, edge detect, shift register, bit counter, CS abort and the timing check. The top level holds the decoder FSM and address generation.

Test Plan:
- Send 0xAF, 0xA0, 0x52 with DC=0 -> 3 o_BYTE_VALID pulses, o_DISPLAY_ON=1, o_REMAP=0x52, no o_CMD_ERR.
- Send 0x15,10,12 then 0x75,5,6 then 7 data bytes 0x01..0x07 -> writes at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6),(10,5), with DATA 0x01..0x07.
- Send 5 bits, raise CS, then a full 0xAE -> exactly one byte (0xAE) is emitted and o_DISPLAY_ON=0.
- Send 0xBB -> one o_CMD_ERR pulse and no state change. Send 0x15,0x70,0x05 -> one o_CMD_ERR pulse and col_start clamped to 95. Send 0x15, 0x03, then a data byte 0x99 -> o_CMD_ERR, pixel written at the old pointer, window unchanged.
- Pulse i_RES low for 10 cycles mid-byte after configuring the window -> display off, remap 0x40, windows at default, the next data byte written at (0,0).
- With SSD1331_RX_TIMING_CHECK_EN defined, use an SCK period of 10 ticks -> o_TIMING_ERR=1 and sticky. A period of 20 ticks from reset -> o_TIMING_ERR stays 0.
